// File: rtl/key_conditioner.sv
// Push-button front end: two-flop synchronizer, counter debouncer and a
// press/short/long classifier producing registered single-cycle events.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press,
    output logic release_pulse,
    output logic short_press,
    output logic long_press
);
    localparam int unsigned   DW           = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned   HW           = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] DLAST        = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HLAST        = HW'(LONG_CYCLES - 1);
    localparam logic          RAW_RELEASED = ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_e;

    logic          sync1_q, sync2_q;
    logic          pressed_c;
    logic          stb_q, stb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          rise_c, fall_c;
    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_q, release_q, short_q, long_q;
    logic          press_d, release_d, short_d, long_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RAW_RELEASED;
            sync2_q <= RAW_RELEASED;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_c = sync2_q ^ ACTIVE_LOW;

    // Accept a new level only after it has differed from stb for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stb_d  = stb_q;
        dcnt_d = '0;
        if (pressed_c != stb_q) begin
            if (dcnt_q == DLAST) begin
                stb_d = pressed_c;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    assign rise_c = stb_d & ~stb_q;
    assign fall_c = ~stb_d & stb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            stb_q  <= stb_d;
            dcnt_q <= dcnt_d;
        end
    end

    // Classifier state and hold counter; events are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                if (rise_c) state_d = S_PRESSED;
            end
            S_PRESSED: begin
                hcnt_d = hcnt_q + HW'(1);
                if (fall_c) begin
                    state_d = S_IDLE;
                end else if (hcnt_q == HLAST) begin
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                if (fall_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A release on the threshold cycle is still a short press.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            S_IDLE: press_d = rise_c;
            S_PRESSED: begin
                release_d = fall_c;
                short_d   = fall_c;
                long_d    = ~fall_c & (hcnt_q == HLAST);
            end
            S_HELD:  release_d = fall_c;
            default: press_d = 1'b0;
        endcase
    end

    assign key_level     = stb_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: scenario tasks compare the DUT each
// cycle against a window-based behavioural model of the key conditioner.
module tb_key_conditioner;
    localparam int D = 4;
    localparam int L = 20;

    logic clk;
    logic rst;
    logic key_in;
    logic key_level, press, release_pulse, short_press, long_press;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_level    (key_level),
        .press        (press),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: level flips when the synchronized key (sample from 2 edges ago)
    // disagreed with it for the last D consecutive samples; hold time in edges.
    bit hist[$];
    bit m_lvl, m_long_done, m_flip;
    int m_t;
    bit e_level, e_press, e_rel, e_short, e_long;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
            m_lvl = 0; m_long_done = 0; m_t = 0;
            e_level = 0; e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
        end else begin
            hist.push_back(!key_in);
            void'(hist.pop_front());
            m_flip = 1;
            for (int i = 0; i < D; i++) if (hist[i] == m_lvl) m_flip = 0;
            e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
            if (m_lvl) m_t++;
            if (m_flip) begin
                m_lvl = !m_lvl;
                if (m_lvl) begin
                    e_press = 1; m_t = 0; m_long_done = 0;
                end else begin
                    e_rel = 1; e_short = !m_long_done;
                end
            end else if (m_lvl && m_t == L && !m_long_done) begin
                e_long = 1; m_long_done = 1;
            end
            e_level = m_lvl;
        end
    end

    logic [4:0] dut_v, exp_v;
    assign dut_v = {key_level, press, release_pulse, short_press, long_press};
    assign exp_v = {e_level, e_press, e_rel, e_short, e_long};

    task automatic test_reset();
        key_in = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_v !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b want %b", dut_v, 5'b0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== 5'b0 || dut_v !== exp_v) begin
                errors++; $display("FAIL reset_idle c=%0d got %b want %b", c, dut_v, 5'b0);
            end
        end
    endtask

    task automatic test_short_press();
        int presses = 0, longs = 0;
        key_in = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL short_model c=%0d got %b want %b", c, dut_v, exp_v);
            end
            presses += int'(press);
            longs += int'(long_press);
            if (c == 5) begin
                checks++;
                if (key_level !== 1'b0) begin
                    errors++; $display("FAIL short_early_level got %b want 0", key_level);
                end
            end
            if (c == 6) begin
                checks++;
                if ({key_level, press} !== 2'b11) begin
                    errors++; $display("FAIL short_press_edge got %b want 11", {key_level, press});
                end
            end
            if (c == 16) begin
                checks++;
                if ({key_level, release_pulse, short_press, long_press} !== 4'b0110) begin
                    errors++; $display("FAIL short_release_edge got %b want 0110",
                                       {key_level, release_pulse, short_press, long_press});
                end
            end
            if (c == 10) key_in = 1'b1;
        end
        checks++;
        if (presses != 1 || longs != 0) begin
            errors++; $display("FAIL short_counts presses=%0d longs=%0d want 1 0", presses, longs);
        end
    endtask

    task automatic test_bounce();
        bit seq[$];
        bit lvl = 1'b0;
        int fall_idx, press_at = -1, presses = 0;
        do begin
            repeat ($urandom_range(1, 3)) seq.push_back(lvl);
            lvl = !lvl;
        end while (seq.size() < 30 || lvl == 1'b1);
        fall_idx = seq.size();
        repeat (12) seq.push_back(1'b0);
        repeat (14) seq.push_back(1'b1);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL bounce_model i=%0d got %b want %b", i, dut_v, exp_v);
            end
            if (press) begin
                presses++;
                press_at = i;
            end
            key_in = seq[i];
        end
        checks++;
        if (presses != 1 || press_at != fall_idx + 6) begin
            errors++; $display("FAIL bounce_press count=%0d at=%0d want 1 at %0d",
                               presses, press_at, fall_idx + 6);
        end
    endtask

    task automatic test_long_press();
        int press_at = -1, long_at = -1, rel_at = -1, shorts = 0;
        key_in = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL long_model c=%0d got %b want %b", c, dut_v, exp_v);
            end
            if (press) press_at = c;
            if (long_press) long_at = c;
            if (release_pulse) rel_at = c;
            shorts += int'(short_press);
            if (c == 40) key_in = 1'b1;
        end
        checks++;
        if (press_at != 6 || long_at != press_at + L) begin
            errors++; $display("FAIL long_timing press_at=%0d long_at=%0d want 6 26", press_at, long_at);
        end
        checks++;
        if (rel_at != 46 || shorts != 0) begin
            errors++; $display("FAIL long_release rel_at=%0d shorts=%0d want 46 0", rel_at, shorts);
        end
    endtask

    task automatic test_boundary();
        int longs = 0;
        key_in = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL boundary_model c=%0d got %b want %b", c, dut_v, exp_v);
            end
            longs += int'(long_press);
            if (c == 26) begin
                checks++;
                if ({release_pulse, short_press, long_press} !== 3'b110) begin
                    errors++; $display("FAIL boundary_edge got %b want 110",
                                       {release_pulse, short_press, long_press});
                end
            end
            if (c == 20) key_in = 1'b1;
        end
        checks++;
        if (longs != 0) begin
            errors++; $display("FAIL boundary_long got %0d want 0", longs);
        end
    endtask

    task automatic test_reset_mid_press();
        int rels = 0, press_at = -1;
        key_in = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL rstmid_model c=%0d got %b want %b", c, dut_v, exp_v);
            end
            if (c >= 13 && c <= 29) rels += int'(release_pulse);
            if (c > 12 && press) press_at = c;
            if (c == 14) begin
                checks++;
                if (dut_v !== 5'b0) begin
                    errors++; $display("FAIL rstmid_in_reset got %b want 00000", dut_v);
                end
            end
            if (c == 12) rst = 1'b1;
            if (c == 15) rst = 1'b0;
            if (c == 24) key_in = 1'b1;
        end
        checks++;
        if (rels != 0 || press_at != 21) begin
            errors++; $display("FAIL rstmid_repress rels=%0d press_at=%0d want 0 21", rels, press_at);
        end
    endtask

    task automatic test_random();
        int presses = 0, shorts = 0, longs = 0, both = 0;
        for (int s = 0; s < 40; s++) begin
            key_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) begin
                @(negedge clk);
                checks++;
                if (dut_v !== exp_v) begin
                    errors++; $display("FAIL random_model seg=%0d got %b want %b", s, dut_v, exp_v);
                end
                presses += int'(press);
                shorts += int'(short_press);
                longs += int'(long_press);
                both += int'(press & release_pulse);
            end
        end
        key_in = 1'b1;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL random_settle got %b want %b", dut_v, exp_v);
            end
            presses += int'(press);
            shorts += int'(short_press);
            longs += int'(long_press);
        end
        checks++;
        if (presses != shorts + longs || both != 0) begin
            errors++; $display("FAIL random_exclusive presses=%0d shorts=%0d longs=%0d overlap=%0d",
                               presses, shorts, longs, both);
        end
    endtask

    initial begin
        rst = 1'b0;
        key_in = 1'b1;
        test_reset();
        test_short_press();
        test_bounce();
        test_long_press();
        test_boundary();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
